// File: rtl/rel_mem_psum_accum_if.sv
// Psum drain bus between the PE array, the mode-0 psum accumulator and the psum GBF.
//   master : accumulator view (consumes psum_out / control pulses, drives RF address and GBF writes)
//   slave  : environment view (PE array + psum GBF)
// Signals:
//   psum_out        PE array -> acc   psum vector of all PEs at psum_rf_addr
//   pe_psum_finish  PE array -> acc   tile finished, start drain
//   conv_finish     ctrl     -> acc   whole convolution finished
//   psum_rf_addr    acc -> PE array   RF address requested
//   su_add_finish   acc -> ctrl       1-cycle pulse, tile drained
//   out_data        acc -> GBF        write data
//   psum_gbf_w_en   acc -> GBF        write enable
//   psum_gbf_w_addr acc -> GBF        write address
//   psum_gbf_w_num  acc -> GBF        active buffer select (0 = buf1, 1 = buf2)
interface rel_mem_psum_accum_if #(
  parameter int ROW                   = 16,
  parameter int COL                   = 16,
  parameter int DATA_BITWIDTH         = 16,
  parameter int GBF_DATA_BITWIDTH     = 512,
  parameter int PSUM_RF_ADDR_BITWIDTH = 2,
  parameter int GBF_ADDR_BITWIDTH     = 5
);
  logic [DATA_BITWIDTH*ROW*COL-1:0] psum_out;
  logic                             pe_psum_finish;
  logic                             conv_finish;
  logic [PSUM_RF_ADDR_BITWIDTH-1:0] psum_rf_addr;
  logic                             su_add_finish;
  logic [GBF_DATA_BITWIDTH-1:0]     out_data;
  logic                             psum_gbf_w_en;
  logic [GBF_ADDR_BITWIDTH-1:0]     psum_gbf_w_addr;
  logic                             psum_gbf_w_num;

  modport master (
    input  psum_out, pe_psum_finish, conv_finish,
    output psum_rf_addr, su_add_finish, out_data,
           psum_gbf_w_en, psum_gbf_w_addr, psum_gbf_w_num
  );

  modport slave (
    output psum_out, pe_psum_finish, conv_finish,
    input  psum_rf_addr, su_add_finish, out_data,
           psum_gbf_w_en, psum_gbf_w_addr, psum_gbf_w_num
  );
endinterface

// File: rtl/rel_mem_psum_accum.sv
// Mode-0 psum drain of the spatial-unrolling adder.
// On pe_psum_finish it walks every PE psum RF address, captures the full ROW*COL psum
// vector and writes it into the psum GBF as WORDS consecutive GBF words, address
// rf*WORDS + word. After the last RF address it pulses su_add_finish and flips the
// active GBF buffer. conv_finish parks the block in FINISH (after any drain in flight).
// Ports:
//   clk    clock, all state on posedge
//   reset  asynchronous, active-high
//   bus    rel_mem_psum_accum_if.master (see interface header for signal list)
// All outputs are registered. When the upstream mux deselects this block its clock and
// inputs are held low, so it simply holds state.
module rel_mem_psum_accum #(
  parameter int ROW                   = 16,
  parameter int COL                   = 16,
  parameter int DATA_BITWIDTH         = 16,
  parameter int GBF_DATA_BITWIDTH     = 512,
  parameter int PSUM_RF_ADDR_BITWIDTH = 2,
  parameter int GBF_ADDR_BITWIDTH     = 5,
  parameter int DEPTH                 = 32
) (
  input  logic                 clk,
  input  logic                 reset,
  rel_mem_psum_accum_if.master bus
);
  localparam int NRF    = 2**PSUM_RF_ADDR_BITWIDTH;
  localparam int VEC_W  = DATA_BITWIDTH*ROW*COL;
  localparam int WORDS  = VEC_W / GBF_DATA_BITWIDTH;
  localparam int WCNT_W = (WORDS > 1) ? $clog2(WORDS) : 1;

  // The vector must split into whole GBF words and all RF addresses must fit one buffer.
  if ((VEC_W % GBF_DATA_BITWIDTH) != 0 || (NRF*WORDS) > DEPTH) begin : g_bad_cfg
    $error("rel_mem_psum_accum: illegal ROW/COL/width/DEPTH combination");
  end

  typedef enum logic [2:0] {
    S_IDLE, S_FETCH, S_LATCH, S_WRITE, S_DONE, S_FINISH
  } state_t;

  state_t                                      state_q, state_d;
  logic [PSUM_RF_ADDR_BITWIDTH-1:0]            rf_cnt_q, rf_cnt_d;
  logic [WCNT_W-1:0]                           word_cnt_q, word_cnt_d;
  logic                                        conv_done_q, conv_done_d;
  logic                                        w_en_q, w_en_d;
  logic                                        su_q, su_d;
  logic [GBF_DATA_BITWIDTH-1:0]                out_data_q, out_data_d;
  logic [GBF_ADDR_BITWIDTH-1:0]                w_addr_q, w_addr_d;
  logic                                        w_num_q, w_num_d;
  logic [WORDS-1:0][GBF_DATA_BITWIDTH-1:0]     buf_q;
  logic                                        buf_ld;

  function automatic logic [GBF_ADDR_BITWIDTH-1:0] word_addr(
    input logic [PSUM_RF_ADDR_BITWIDTH-1:0] rf,
    input logic [WCNT_W-1:0]                wd
  );
    return GBF_ADDR_BITWIDTH'(rf) * GBF_ADDR_BITWIDTH'(WORDS) + GBF_ADDR_BITWIDTH'(wd);
  endfunction

  // Control/output state register
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q     <= S_IDLE;
      rf_cnt_q    <= '0;
      word_cnt_q  <= '0;
      conv_done_q <= 1'b0;
      w_en_q      <= 1'b0;
      su_q        <= 1'b0;
      out_data_q  <= '0;
      w_addr_q    <= '0;
      w_num_q     <= 1'b0;
    end else begin
      state_q     <= state_d;
      rf_cnt_q    <= rf_cnt_d;
      word_cnt_q  <= word_cnt_d;
      conv_done_q <= conv_done_d;
      w_en_q      <= w_en_d;
      su_q        <= su_d;
      out_data_q  <= out_data_d;
      w_addr_q    <= w_addr_d;
      w_num_q     <= w_num_d;
    end
  end

  // Captured psum vector; pure data, never needs a reset value.
  always_ff @(posedge clk) begin
    if (buf_ld) buf_q <= bus.psum_out;
  end

  always_comb begin
    state_d     = state_q;
    rf_cnt_d    = rf_cnt_q;
    word_cnt_d  = word_cnt_q;
    conv_done_d = conv_done_q;
    w_en_d      = 1'b0;
    su_d        = 1'b0;
    out_data_d  = out_data_q;
    w_addr_d    = w_addr_q;
    w_num_d     = w_num_q;
    buf_ld      = 1'b0;

    // A convolution end seen mid-drain is remembered; the tile still finishes.
    if (bus.conv_finish && (state_q inside {S_FETCH, S_LATCH, S_WRITE, S_DONE}))
      conv_done_d = 1'b1;

    case (state_q)
      S_IDLE: begin
        if (bus.conv_finish) begin
          state_d = S_FINISH;
        end else if (bus.pe_psum_finish) begin
          state_d  = S_FETCH;
          rf_cnt_d = '0;
        end
      end
      S_FETCH: begin
        // RF address is stable; the PE array answers one cycle later.
        state_d = S_LATCH;
      end
      S_LATCH: begin
        // Word 0 comes straight from psum_out so the first write lines up with buf capture.
        buf_ld     = 1'b1;
        word_cnt_d = '0;
        w_en_d     = 1'b1;
        out_data_d = bus.psum_out[GBF_DATA_BITWIDTH-1:0];
        w_addr_d   = word_addr(rf_cnt_q, '0);
        state_d    = S_WRITE;
      end
      S_WRITE: begin
        if (word_cnt_q == WCNT_W'(WORDS-1)) begin
          if (rf_cnt_q == '1) begin
            state_d  = S_DONE;
            su_d     = 1'b1;
            w_num_d  = ~w_num_q;
            rf_cnt_d = '0;
          end else begin
            rf_cnt_d = rf_cnt_q + PSUM_RF_ADDR_BITWIDTH'(1);
            state_d  = S_FETCH;
          end
        end else begin
          word_cnt_d = word_cnt_q + WCNT_W'(1);
          w_en_d     = 1'b1;
          out_data_d = buf_q[word_cnt_d];
          w_addr_d   = word_addr(rf_cnt_q, word_cnt_d);
        end
      end
      S_DONE: begin
        state_d = (conv_done_q || bus.conv_finish) ? S_FINISH : S_IDLE;
      end
      S_FINISH: begin
        state_d = S_FINISH;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  assign bus.psum_rf_addr    = rf_cnt_q;
  assign bus.su_add_finish   = su_q;
  assign bus.out_data        = out_data_q;
  assign bus.psum_gbf_w_en   = w_en_q;
  assign bus.psum_gbf_w_addr = w_addr_q;
  assign bus.psum_gbf_w_num  = w_num_q;

endmodule

// File: tb/tb_rel_mem_psum_accum.sv
module tb_rel_mem_psum_accum;
  localparam int ROW   = 16;
  localparam int COL   = 16;
  localparam int DW    = 16;
  localparam int GW    = 512;
  localparam int RAW   = 2;
  localparam int GAW   = 5;
  localparam int DEPTH = 32;
  localparam int NRF   = 1 << RAW;
  localparam int WORDS = DW*ROW*COL/GW;
  localparam int LPW   = GW/DW;
  localparam int LAT   = NRF*(WORDS+2)+1;
  localparam int VW    = DW*ROW*COL;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  rel_mem_psum_accum_if #(
    .ROW(ROW), .COL(COL), .DATA_BITWIDTH(DW), .GBF_DATA_BITWIDTH(GW),
    .PSUM_RF_ADDR_BITWIDTH(RAW), .GBF_ADDR_BITWIDTH(GAW)
  ) bus ();

  rel_mem_psum_accum #(
    .ROW(ROW), .COL(COL), .DATA_BITWIDTH(DW), .GBF_DATA_BITWIDTH(GW),
    .PSUM_RF_ADDR_BITWIDTH(RAW), .GBF_ADDR_BITWIDTH(GAW), .DEPTH(DEPTH)
  ) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  typedef struct { logic [GAW-1:0] addr; logic [GW-1:0] data; } wr_t;
  typedef struct { int cyc; logic wnum; } su_t;

  wr_t  wr_q[$];
  su_t  su_q[$];
  int   checks = 0;
  int   fails  = 0;
  int   cyc    = 0;
  int   nwr    = 0;
  int   nsu    = 0;
  bit   mon_en = 1'b0;
  logic wnum_exp = 1'b0;
  logic [15:0] salt = 16'h0;

  // PE array RF model: lane i of rf r holds i + 256*r + salt, one-cycle read latency.
  logic [VW-1:0] rf_data;
  always @(posedge clk) begin
    for (int i = 0; i < ROW*COL; i++)
      rf_data[DW*i +: DW] <= DW'(i + 256*int'(bus.psum_rf_addr)) + salt;
  end
  assign bus.psum_out = rf_data;

  function automatic logic [GW-1:0] exp_word(input int rf, input int k, input logic [15:0] s);
    logic [GW-1:0] w;
    for (int j = 0; j < LPW; j++) w[DW*j +: DW] = DW'(k*LPW + j + rf*256) + s;
    return w;
  endfunction

  task automatic chk(input string name, input logic [GW-1:0] got, input logic [GW-1:0] exp);
    checks++;
    if (got !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h", name, got, exp);
    end
  endtask

  // Monitor / scoreboard
  initial begin
    forever begin
      @(posedge clk);
      cyc++;
      #1;
      if (mon_en) begin
        if (bus.psum_gbf_w_en === 1'b1) begin
          wr_t e;
          nwr++;
          checks++;
          if (wr_q.size() == 0) begin
            fails++;
            $display("FAIL unexpected_write: addr %0d at cycle %0d, none expected", bus.psum_gbf_w_addr, cyc);
          end else begin
            e = wr_q.pop_front();
            if (bus.psum_gbf_w_addr !== e.addr || bus.out_data !== e.data) begin
              fails++;
              $display("FAIL gbf_write: got addr %0d data %0h, expected addr %0d data %0h",
                       bus.psum_gbf_w_addr, bus.out_data, e.addr, e.data);
            end
          end
        end
        if (bus.su_add_finish === 1'b1) begin
          su_t s;
          nsu++;
          checks++;
          if (su_q.size() == 0) begin
            fails++;
            $display("FAIL unexpected_su_add_finish at cycle %0d", cyc);
          end else begin
            s = su_q.pop_front();
            if (cyc != s.cyc || bus.psum_gbf_w_num !== s.wnum) begin
              fails++;
              $display("FAIL su_add_finish: got cycle %0d w_num %0b, expected cycle %0d w_num %0b",
                       cyc, bus.psum_gbf_w_num, s.cyc, s.wnum);
            end
          end
        end
      end
    end
  end

  task automatic issue_tile(input logic [15:0] s);
    int t;
    salt = s;
    @(negedge clk);
    t = cyc;
    for (int rf = 0; rf < NRF; rf++)
      for (int k = 0; k < WORDS; k++)
        wr_q.push_back('{addr: GAW'(rf*WORDS + k), data: exp_word(rf, k, s)});
    wnum_exp = ~wnum_exp;
    su_q.push_back('{cyc: t + LAT, wnum: wnum_exp});
    bus.pe_psum_finish = 1'b1;
    @(negedge clk);
    bus.pe_psum_finish = 1'b0;
  endtask

  task automatic wait_drain(input int budget);
    int n = 0;
    while ((wr_q.size() != 0 || su_q.size() != 0) && n < budget) begin
      @(negedge clk);
      n++;
    end
    checks++;
    if (wr_q.size() != 0 || su_q.size() != 0) begin
      fails++;
      $display("FAIL drain_timeout: %0d writes and %0d finish pulses still pending", wr_q.size(), su_q.size());
      wr_q.delete();
      su_q.delete();
    end
    repeat (2) @(negedge clk);
  endtask

  task automatic chk_outputs_zero(input string tag);
    chk({tag, "_w_en"},    GW'(bus.psum_gbf_w_en),   '0);
    chk({tag, "_su"},      GW'(bus.su_add_finish),   '0);
    chk({tag, "_data"},    bus.out_data,             '0);
    chk({tag, "_w_addr"},  GW'(bus.psum_gbf_w_addr), '0);
    chk({tag, "_w_num"},   GW'(bus.psum_gbf_w_num),  '0);
    chk({tag, "_rf_addr"}, GW'(bus.psum_rf_addr),    '0);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int w0, s0;
    bus.pe_psum_finish = 1'b0;
    bus.conv_finish    = 1'b0;
    reset = 1'b1;
    repeat (3) @(negedge clk);
    chk_outputs_zero("reset");
    reset  = 1'b0;
    mon_en = 1'b1;
    @(negedge clk);

    // Single tile: 32 writes, finish 41 cycles after the pulse, w_num 0->1
    w0 = nwr; s0 = nsu;
    issue_tile(16'h0000);
    wait_drain(LAT + 10);
    chk("tile1_writes", GW'(nwr - w0), GW'(NRF*WORDS));
    chk("tile1_su",     GW'(nsu - s0), GW'(1));
    chk("tile1_w_num",  GW'(bus.psum_gbf_w_num), GW'(1));

    // Asynchronous reset in the middle of WRITE
    mon_en = 1'b0;
    salt = 16'h0100;
    @(negedge clk);
    bus.pe_psum_finish = 1'b1;
    @(negedge clk);
    bus.pe_psum_finish = 1'b0;
    repeat (5) @(negedge clk);
    chk("midwrite_w_en", GW'(bus.psum_gbf_w_en), GW'(1));
    #2 reset = 1'b1;
    #1 chk_outputs_zero("async_reset");
    @(negedge clk);
    reset = 1'b0;
    wr_q.delete();
    su_q.delete();
    wnum_exp = 1'b0;
    mon_en = 1'b1;
    repeat (5) @(negedge clk);

    // Two tiles back to back: w_num 0->1->0, addresses restart at 0
    w0 = nwr; s0 = nsu;
    issue_tile(16'h1000);
    wait_drain(LAT + 10);
    chk("b2b_w_num_a", GW'(bus.psum_gbf_w_num), GW'(1));
    issue_tile(16'h2000);
    wait_drain(LAT + 10);
    chk("b2b_w_num_b", GW'(bus.psum_gbf_w_num), GW'(0));
    chk("b2b_writes",  GW'(nwr - w0), GW'(2*NRF*WORDS));
    chk("b2b_su",      GW'(nsu - s0), GW'(2));

    // Re-pulse during WRITE is ignored
    w0 = nwr; s0 = nsu;
    issue_tile(16'h3000);
    repeat (6) @(negedge clk);
    bus.pe_psum_finish = 1'b1;
    @(negedge clk);
    bus.pe_psum_finish = 1'b0;
    wait_drain(LAT + 10);
    repeat (LAT + 5) @(negedge clk);
    chk("repulse_writes", GW'(nwr - w0), GW'(NRF*WORDS));
    chk("repulse_su",     GW'(nsu - s0), GW'(1));

    // conv_finish mid-drain: tile completes, then FINISH ignores new tiles
    w0 = nwr; s0 = nsu;
    issue_tile(16'h4000);
    repeat (15) @(negedge clk);
    bus.conv_finish = 1'b1;
    @(negedge clk);
    bus.conv_finish = 1'b0;
    wait_drain(LAT + 10);
    repeat (3) @(negedge clk);
    bus.pe_psum_finish = 1'b1;
    @(negedge clk);
    bus.pe_psum_finish = 1'b0;
    repeat (LAT + 5) @(negedge clk);
    chk("conv_writes", GW'(nwr - w0), GW'(NRF*WORDS));
    chk("conv_su",     GW'(nsu - s0), GW'(1));
    chk("conv_w_num_frozen", GW'(bus.psum_gbf_w_num), GW'(wnum_exp));

    // conv_finish together with pe_psum_finish in IDLE -> FINISH, no writes
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    wnum_exp = 1'b0;
    @(negedge clk);
    w0 = nwr; s0 = nsu;
    bus.conv_finish    = 1'b1;
    bus.pe_psum_finish = 1'b1;
    @(negedge clk);
    bus.conv_finish    = 1'b0;
    bus.pe_psum_finish = 1'b0;
    repeat (LAT + 5) @(negedge clk);
    bus.pe_psum_finish = 1'b1;
    @(negedge clk);
    bus.pe_psum_finish = 1'b0;
    repeat (LAT + 5) @(negedge clk);
    chk("idle_conv_writes", GW'(nwr - w0), GW'(0));
    chk("idle_conv_su",     GW'(nsu - s0), GW'(0));
    chk("idle_conv_w_num",  GW'(bus.psum_gbf_w_num), GW'(0));

    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end
endmodule
